// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 access-size codes
// and the controller state encoding.
package load_store_unit_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_REQ   = 2'b01,
      S_DONE  = 2'b10,
      S_FAULT = 2'b11
   } lsu_state_t;

   // Reason recorded when an access ends in the FAULT state.
   typedef enum logic [0:0] {
      FC_MISALIGN = 1'b0,
      FC_TIMEOUT  = 1'b1
   } fault_cause_t;

   // Word-aligned address presented on the memory port.
   function automatic logic [31:0] word_addr(input logic [31:0] byte_addr);
      return {byte_addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Data-memory request/acknowledge port. The LSU is the master; the memory
// (or its model) is the slave and answers with mem_ack/mem_rdata.
interface load_store_unit_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic [31:0] mem_rdata;
   logic        mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
      output mem_rdata, mem_ack
   );
endinterface

// File: rtl/load_store_unit_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store
// data, sign/zero-extended load data and the alignment/legality check.
// Purely combinational.
module lsu_align
   import load_store_unit_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic        is_store,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wdata,
   input  logic [31:0] mem_rdata,
   output logic [3:0]  be,
   output logic [31:0] wdata_lanes,
   output logic [31:0] rdata_ext,
   output logic        misaligned
);

   logic [31:0] shifted_s;

   // Move the addressed byte/half down to bit 0 so extraction is lane-independent.
   assign shifted_s = mem_rdata >> {addr_lo, 3'b000};

   // Decode access size into lanes, extension and fault flag.
   always_comb begin
      be          = 4'b0000;
      wdata_lanes = 32'h0000_0000;
      rdata_ext   = 32'h0000_0000;
      misaligned  = 1'b0;
      case (funct3)
         F3_B: begin
            be          = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {{24{shifted_s[7]}}, shifted_s[7:0]};
            misaligned  = 1'b0;
         end
         F3_BU: begin
            be          = 4'b0001 << addr_lo;
            wdata_lanes = {4{wdata[7:0]}};
            rdata_ext   = {24'h00_0000, shifted_s[7:0]};
            misaligned  = is_store;              // no unsigned store form
         end
         F3_H: begin
            be          = 4'b0011 << addr_lo;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {{16{shifted_s[15]}}, shifted_s[15:0]};
            misaligned  = addr_lo[0];
         end
         F3_HU: begin
            be          = 4'b0011 << addr_lo;
            wdata_lanes = {2{wdata[15:0]}};
            rdata_ext   = {16'h0000, shifted_s[15:0]};
            misaligned  = addr_lo[0] | is_store;
         end
         F3_W: begin
            be          = 4'b1111;
            wdata_lanes = wdata;
            rdata_ext   = mem_rdata;
            misaligned  = (addr_lo != 2'b00);
         end
         default: begin
            misaligned  = 1'b1;                  // illegal funct3 faults like a misalignment
         end
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: takes the ALU effective address, runs one access on
// the req/ack data-memory port and reports completion, misalignment or
// timeout with a one-cycle done pulse. All outputs come straight from flops.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int TIMEOUT_CYC = 255
)(
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               is_store,
   input  logic [2:0]         funct3,
   input  logic [31:0]        addr,
   input  logic [31:0]        wdata,
   output logic               busy,
   output logic               done,
   output logic [31:0]        rdata,
   output logic               misalign,
   output logic               timeout,
   load_store_unit_if.master  mem
);

   localparam logic [7:0] TIMEOUT_LIM = 8'(TIMEOUT_CYC);

   lsu_state_t   state_r, state_s;
   logic [2:0]   funct3_r, funct3_s;
   logic [1:0]   addr_lo_r, addr_lo_s;
   logic         is_store_r, is_store_s;
   fault_cause_t cause_r, cause_s;
   logic [7:0]   cnt_r, cnt_s;

   logic         busy_r, busy_s;
   logic         done_r, done_s;
   logic [31:0]  rdata_r, rdata_s;
   logic         misalign_r, misalign_s;
   logic         timeout_r, timeout_s;
   logic         mem_req_r, mem_req_s;
   logic         mem_we_r, mem_we_s;
   logic [31:0]  mem_addr_r, mem_addr_s;
   logic [31:0]  mem_wdata_r, mem_wdata_s;
   logic [3:0]   mem_be_r, mem_be_s;

   logic [2:0]   al_funct3_s;
   logic         al_is_store_s;
   logic [1:0]   al_addr_lo_s;
   logic [3:0]   al_be_s;
   logic [31:0]  al_wdata_s;
   logic [31:0]  al_rdata_s;
   logic         al_mis_s;
   logic         cnt_expired_s;

   // Aligner sees the live request while idle (to set up the port) and the
   // latched request afterwards (to extract the returned load data).
   always_comb begin
      if (state_r == S_IDLE) begin
         al_funct3_s   = funct3;
         al_is_store_s = is_store;
         al_addr_lo_s  = addr[1:0];
      end else begin
         al_funct3_s   = funct3_r;
         al_is_store_s = is_store_r;
         al_addr_lo_s  = addr_lo_r;
      end
   end

   lsu_align u_align (
      .funct3      (al_funct3_s),
      .is_store    (al_is_store_s),
      .addr_lo     (al_addr_lo_s),
      .wdata       (wdata),
      .mem_rdata   (mem.mem_rdata),
      .be          (al_be_s),
      .wdata_lanes (al_wdata_s),
      .rdata_ext   (al_rdata_s),
      .misaligned  (al_mis_s)
   );

   // This REQ cycle is the last one allowed without an acknowledge.
   assign cnt_expired_s = (({1'b0, cnt_r} + 9'd1) >= {1'b0, TIMEOUT_LIM});

   // Next-state and next-output decode; pulses default low every cycle.
   always_comb begin
      state_s     = state_r;
      funct3_s    = funct3_r;
      addr_lo_s   = addr_lo_r;
      is_store_s  = is_store_r;
      cause_s     = cause_r;
      cnt_s       = cnt_r;
      busy_s      = busy_r;
      done_s      = 1'b0;
      misalign_s  = 1'b0;
      timeout_s   = 1'b0;
      rdata_s     = rdata_r;
      mem_req_s   = 1'b0;
      mem_we_s    = 1'b0;
      mem_addr_s  = mem_addr_r;
      mem_wdata_s = mem_wdata_r;
      mem_be_s    = mem_be_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               funct3_s   = funct3;
               addr_lo_s  = addr[1:0];
               is_store_s = is_store;
               cnt_s      = 8'd0;
               busy_s     = 1'b1;
               if (al_mis_s) begin
                  state_s = S_FAULT;
                  cause_s = FC_MISALIGN;
               end else begin
                  state_s     = S_REQ;
                  mem_req_s   = 1'b1;
                  mem_we_s    = is_store;
                  mem_addr_s  = word_addr(addr);
                  mem_wdata_s = al_wdata_s;
                  mem_be_s    = al_be_s;
               end
            end else begin
               state_s = S_IDLE;
               busy_s  = 1'b0;
            end
         end
         S_REQ: begin
            busy_s = 1'b1;
            if (mem.mem_ack) begin
               state_s = S_DONE;
               done_s  = 1'b1;
               if (!is_store_r) begin
                  rdata_s = al_rdata_s;
               end else begin
                  rdata_s = rdata_r;
               end
            end else if (cnt_expired_s) begin
               state_s = S_FAULT;
               cause_s = FC_TIMEOUT;
               cnt_s   = cnt_r + 8'd1;
            end else begin
               mem_req_s = 1'b1;
               mem_we_s  = is_store_r;
               cnt_s     = cnt_r + 8'd1;
            end
         end
         S_FAULT: begin
            // Completion is reported through the DONE cycle with the cause flag.
            busy_s     = 1'b1;
            state_s    = S_DONE;
            done_s     = 1'b1;
            misalign_s = (cause_r == FC_MISALIGN);
            timeout_s  = (cause_r == FC_TIMEOUT);
         end
         S_DONE: begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
         default: begin
            busy_s  = 1'b0;
            state_s = S_IDLE;
         end
      endcase
   end

   // State, request context and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r     <= S_IDLE;
         funct3_r    <= 3'b000;
         addr_lo_r   <= 2'b00;
         is_store_r  <= 1'b0;
         cause_r     <= FC_MISALIGN;
         cnt_r       <= 8'd0;
         busy_r      <= 1'b0;
         done_r      <= 1'b0;
         rdata_r     <= 32'h0000_0000;
         misalign_r  <= 1'b0;
         timeout_r   <= 1'b0;
         mem_req_r   <= 1'b0;
         mem_we_r    <= 1'b0;
         mem_addr_r  <= 32'h0000_0000;
         mem_wdata_r <= 32'h0000_0000;
         mem_be_r    <= 4'b0000;
      end else begin
         state_r     <= state_s;
         funct3_r    <= funct3_s;
         addr_lo_r   <= addr_lo_s;
         is_store_r  <= is_store_s;
         cause_r     <= cause_s;
         cnt_r       <= cnt_s;
         busy_r      <= busy_s;
         done_r      <= done_s;
         rdata_r     <= rdata_s;
         misalign_r  <= misalign_s;
         timeout_r   <= timeout_s;
         mem_req_r   <= mem_req_s;
         mem_we_r    <= mem_we_s;
         mem_addr_r  <= mem_addr_s;
         mem_wdata_r <= mem_wdata_s;
         mem_be_r    <= mem_be_s;
      end
   end

   assign busy          = busy_r;
   assign done          = done_r;
   assign rdata         = rdata_r;
   assign misalign      = misalign_r;
   assign timeout       = timeout_r;
   assign mem.mem_req   = mem_req_r;
   assign mem.mem_we    = mem_we_r;
   assign mem.mem_addr  = mem_addr_r;
   assign mem.mem_wdata = mem_wdata_r;
   assign mem.mem_be    = mem_be_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit. A transaction-level model derives the
// expected port behaviour of every cycle from the access rules; a single
// compare process checks the DUT against it on each falling edge, and
// literal expectations pin the model on the documented example accesses.
module tb_load_store_unit;

   localparam int TO = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        is_store = 1'b0;
   logic [2:0]  funct3 = 3'b000;
   logic [31:0] addr = 32'h0;
   logic [31:0] wdata = 32'h0;
   logic        busy, done, misalign, timeout;
   logic [31:0] rdata;

   load_store_unit_if mem_bus();

   load_store_unit #(.TIMEOUT_CYC(TO)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .is_store (is_store),
      .funct3   (funct3),
      .addr     (addr),
      .wdata    (wdata),
      .busy     (busy),
      .done     (done),
      .rdata    (rdata),
      .misalign (misalign),
      .timeout  (timeout),
      .mem      (mem_bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Expected outputs for the cycle currently in progress.
   bit          chk_en = 1'b0;
   logic        m_busy = 1'b0, m_done = 1'b0, m_mis = 1'b0, m_to = 1'b0;
   logic        m_req = 1'b0, m_we = 1'b0;
   logic [31:0] m_addr = 32'h0, m_wd = 32'h0, m_rdata = 32'h0;
   logic [3:0]  m_be = 4'h0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model (access rules as arithmetic) ----------------
   function automatic int msize(input logic [2:0] f3);
      case (f3)
         3'b000, 3'b100: return 1;
         3'b001, 3'b101: return 2;
         default:        return 4;
      endcase
   endfunction

   function automatic bit model_bad(input bit st, input logic [2:0] f3, input logic [31:0] a);
      if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b1;
      if (st && f3[2]) return 1'b1;
      return (a % msize(f3)) != 0;
   endfunction

   function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
      int t;
      t = ((1 << msize(f3)) - 1) << (a % 4);
      return t[3:0];
   endfunction

   function automatic logic [31:0] model_wd(input logic [2:0] f3, input logic [31:0] wd);
      case (msize(f3))
         1:       return (wd & 32'hFF) * 32'h0101_0101;
         2:       return (wd & 32'hFFFF) * 32'h0001_0001;
         default: return wd;
      endcase
   endfunction

   function automatic logic [31:0] model_ld(input logic [2:0] f3, input logic [31:0] a,
                                            input logic [31:0] word);
      logic [31:0] v, mask;
      if (msize(f3) == 4) return word;
      mask = (msize(f3) == 1) ? 32'hFF : 32'hFFFF;
      v = (word >> (8 * (a % 4))) & mask;
      if (!f3[2] && v >= (mask + 32'd1) / 32'd2) v = v | ~mask;
      return v;
   endfunction

   // Compare process: every output against the model on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", busy, m_busy);
         chk("done", done, m_done);
         chk("rdata", rdata, m_rdata);
         chk("misalign", misalign, m_mis);
         chk("timeout", timeout, m_to);
         chk("mem_req", mem_bus.mem_req, m_req);
         if (m_req) begin
            chk("mem_we", mem_bus.mem_we, m_we);
            chk("mem_addr", mem_bus.mem_addr, m_addr);
            chk("mem_be", mem_bus.mem_be, m_be);
            chk("mem_wdata", mem_bus.mem_wdata, m_wd);
         end
      end
   end

   // One access: ack_wait = REQ cycle index receiving mem_ack (>= TO: never).
   // hold_start keeps start high with scrambled inputs while busy; noise
   // drives mem_ack outside REQ. use_lit enables the literal expectations.
   task automatic access(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] word, input int ack_wait,
                         input bit hold_start, input bit noise, input bit use_lit,
                         input logic [3:0] lit_be, input logic [31:0] lit_addr,
                         input logic [31:0] lit_wd, input logic [31:0] lit_rd);
      bit          bad, acked;
      logic [3:0]  be_e;
      logic [31:0] wd_e, rd_e;
      bad  = model_bad(st, f3, a);
      be_e = model_be(f3, a);
      wd_e = model_wd(f3, wd);
      rd_e = model_ld(f3, a, word);
      // cycle t: idle, request presented
      @(posedge clk); #1;
      start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
      mem_bus.mem_ack = noise; mem_bus.mem_rdata = 32'h5A5A_5A5A;
      m_busy = 1'b0; m_done = 1'b0; m_mis = 1'b0; m_to = 1'b0; m_req = 1'b0;
      @(posedge clk); #1;
      if (hold_start) begin
         addr = a + 32'h40; is_store = ~st; funct3 = 3'b111; wdata = ~wd;
      end else begin
         start = 1'b0;
      end
      mem_bus.mem_ack = 1'b0;
      if (bad) begin
         m_busy = 1'b1; m_done = 1'b0; m_req = 1'b0;
         mem_bus.mem_ack = noise;
         @(posedge clk); #1;
         m_done = 1'b1; m_mis = 1'b1;
      end else begin
         acked = 1'b0;
         for (int k = 0; k < TO && !acked; k++) begin
            m_busy = 1'b1; m_done = 1'b0; m_req = 1'b1; m_we = st;
            m_addr = {a[31:2], 2'b00}; m_be = be_e; m_wd = wd_e;
            if (k == ack_wait) begin
               mem_bus.mem_ack = 1'b1; mem_bus.mem_rdata = word; acked = 1'b1;
            end else begin
               mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = 32'h5A5A_5A5A;
            end
            if (use_lit && k == 0) begin
               #1;
               chk("lit_mem_be", mem_bus.mem_be, lit_be);
               chk("lit_mem_addr", mem_bus.mem_addr, lit_addr);
               if (st) chk("lit_mem_wdata", mem_bus.mem_wdata, lit_wd);
            end
            @(posedge clk); #1;
         end
         mem_bus.mem_ack = noise; mem_bus.mem_rdata = 32'h5A5A_5A5A;
         m_req = 1'b0;
         if (acked) begin
            m_done = 1'b1;
            if (!st) m_rdata = rd_e;
         end else begin
            m_done = 1'b0;
            @(posedge clk); #1;
            m_done = 1'b1; m_to = 1'b1;
         end
      end
      // done cycle is now in progress
      if (use_lit && !st && !bad) begin
         #1;
         chk("lit_rdata", rdata, lit_rd);
      end
      @(posedge clk); #1;
      start = 1'b0; mem_bus.mem_ack = 1'b0;
      m_busy = 1'b0; m_done = 1'b0; m_mis = 1'b0; m_to = 1'b0; m_req = 1'b0;
   endtask

   initial begin
      mem_bus.mem_ack   = 1'b0;
      mem_bus.mem_rdata = 32'h0;
      // reset values while rst is asserted
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_mem_req", mem_bus.mem_req, 1'b0);
      chk("rst_mem_we", mem_bus.mem_we, 1'b0);
      chk("rst_mem_be", mem_bus.mem_be, 4'b0000);
      chk("rst_mem_addr", mem_bus.mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_bus.mem_wdata, 32'h0);
      chk("rst_rdata", rdata, 32'h0);
      rst = 1'b0;
      chk_en = 1'b1;

      //     st    f3      addr          wdata         mem word      ack hold noise lit  be       addr          wdata         rdata
      access(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF);
      access(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8000_0000, 0, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFF_FF80);
      access(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8000_0000, 1, 1'b0, 1'b0, 1'b1, 4'b1000, 32'h0000_0100, 32'h0,        32'h0000_0080);
      access(1'b0, 3'b101, 32'h0000_0102, 32'h0,        32'hBEEF_1234, 0, 1'b0, 1'b1, 1'b1, 4'b1100, 32'h0000_0100, 32'h0,        32'h0000_BEEF);
      access(1'b1, 3'b000, 32'h0000_0101, 32'h0000_00AB, 32'h0,        0, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_0100, 32'hABAB_ABAB, 32'h0);
      access(1'b1, 3'b001, 32'h0000_0106, 32'h1234_CAFE, 32'h0,        2, 1'b1, 1'b1, 1'b1, 4'b1100, 32'h0000_0104, 32'hCAFE_CAFE, 32'h0);
      access(1'b0, 3'b001, 32'h0000_010A, 32'h0,        32'h8001_7FFF, 0, 1'b1, 1'b0, 1'b1, 4'b1100, 32'h0000_0108, 32'h0,        32'hFFFF_8001);
      access(1'b0, 3'b000, 32'h0000_0112, 32'h0,        32'h007F_0000, 0, 1'b0, 1'b0, 1'b1, 4'b0100, 32'h0000_0110, 32'h0,        32'h0000_007F);
      access(1'b1, 3'b010, 32'h0000_010C, 32'h0123_4567, 32'h0,        3, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_010C, 32'h0123_4567, 32'h0);
      // faults: misaligned word/half, unsigned store, illegal funct3, timeout
      access(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,         0, 1'b0, 1'b1, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0);
      access(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,         0, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0);
      access(1'b1, 3'b100, 32'h0000_0100, 32'h55,       32'h0,         0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0);
      access(1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,         0, 1'b0, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0);
      access(1'b0, 3'b010, 32'h0000_0200, 32'h0,        32'h0,        TO, 1'b1, 1'b0, 1'b0, 4'b0000, 32'h0,        32'h0,        32'h0);
      access(1'b0, 3'b010, 32'h0000_0204, 32'h0,        32'hCAFE_F00D, 0, 1'b0, 1'b0, 1'b1, 4'b1111, 32'h0000_0204, 32'h0,        32'hCAFE_F00D);

      // reset in the middle of a request with start held high
      @(posedge clk); #1;
      start = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h0000_0300;
      @(posedge clk); #1;
      chk_en = 1'b0;
      chk("pre_rst_mem_req", mem_bus.mem_req, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("async_mem_req", mem_bus.mem_req, 1'b0);
      chk("async_busy", busy, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_no_done", done, 1'b0);
         chk("rst_hold_busy", busy, 1'b0);
      end
      @(posedge clk); #1;
      start = 1'b0; rst = 1'b0;
      m_rdata = 32'h0; m_busy = 1'b0; m_done = 1'b0; m_req = 1'b0; m_mis = 1'b0; m_to = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      chk("post_rst_rdata", rdata, 32'h0);
      access(1'b0, 3'b000, 32'h0000_0301, 32'h0,        32'h0000_F000, 0, 1'b0, 1'b0, 1'b1, 4'b0010, 32'h0000_0300, 32'h0,        32'hFFFF_FFF0);

      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
